epu_v2: RTL and testbench

//  Second-generation error processing unit of the ADPLL; sits between the TDC/frequency counter and the

---
 rtl/epu_v2_pkg.sv | 26 ++
 rtl/epu_v2_if.sv | 38 +++
 rtl/epu_v2_lock_tracker.sv | 72 +++++++
 rtl/therm_to_bin.sv | 13 +
 rtl/epu_v2.sv | 93 +++++++++
 tb/tb_epu_v2.sv | 218 +++++++++++++++++++++
 6 files changed

// File: rtl/epu_v2_pkg.sv
// Shared types and helpers for the second-generation ADPLL error processing unit.
// Holds the FSM state encoding and the signed saturation helper.
package epu_pkg;

  typedef enum logic [1:0] {
    RESET    = 2'd0,
    F_LOCKED = 2'd1,
    F_SLOW   = 2'd2,
    F_FAST   = 2'd3
  } f_mode_t;

  localparam int ERR_SIZE_DEF = 8;
  localparam int ERR_MAX      = 2**(ERR_SIZE_DEF-1) - 1;
  localparam int ERR_MIN      = -(2**(ERR_SIZE_DEF-1));

  // Clamp x to the signed range of a w-bit word; caller truncates to w bits.
  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (w-1)) - 32'sd1;
    lo = -(32'sd1 <<< (w-1));
    if (x > hi)      return hi;
    else if (x < lo) return lo;
    else             return x;
  endfunction

endpackage

// File: rtl/epu_v2_if.sv
// Measurement/config/result bundle between the frequency counter, TDC and the EPU.
interface epu_v2_if #(
  parameter int ERR_SIZE   = 8,
  parameter int N_SIZE     = 8,
  parameter int TDC_SIZE   = 255,
  parameter int RANGE_W    = 2,
  parameter int LOCK_CNT_W = 10,
  parameter int MISS_W     = 3
);
  logic                  enable;
  logic                  freq_valid;
  logic [N_SIZE-1:0]     freq;
  logic [N_SIZE-1:0]     n;
  logic [RANGE_W-1:0]    freq_lock_range;
  logic                  mode_prop;
  logic [LOCK_CNT_W-1:0] lock_target;
  logic [ERR_SIZE-2:0]   phase_window;
  logic [MISS_W-1:0]     unlock_misses;
  logic [TDC_SIZE-1:0]   tdc_therm;
  logic [ERR_SIZE-1:0]   epu_out;
  logic [ERR_SIZE-1:0]   therm_to_bin_out;
  logic [1:0]            f_mode;
  logic                  freq_locked;
  logic                  phase_locked;
  logic                  lock_lost;

  modport master (
    output enable, freq_valid, freq, n, freq_lock_range, mode_prop, lock_target,
           phase_window, unlock_misses, tdc_therm,
    input  epu_out, therm_to_bin_out, f_mode, freq_locked, phase_locked, lock_lost
  );

  modport slave (
    input  enable, freq_valid, freq, n, freq_lock_range, mode_prop, lock_target,
           phase_window, unlock_misses, tdc_therm,
    output epu_out, therm_to_bin_out, f_mode, freq_locked, phase_locked, lock_lost
  );
endinterface

// File: rtl/epu_v2_lock_tracker.sv
// Lock qualifier: saturating hit counter, flag, and miss hysteresis before the flag drops.
module epu_lock_tracker #(
  parameter int CNT_W  = 10,
  parameter int MISS_W = 3
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clr,
  input  logic              kill,
  input  logic              eval,
  input  logic              hit,
  input  logic [CNT_W-1:0]  target,
  input  logic [MISS_W-1:0] misses,
  output logic              flag,
  output logic              lost,
  output logic              drop
);
  logic [CNT_W-1:0]  cnt_q, cnt_d, tgt;
  logic [MISS_W-1:0] miss_q, miss_d, mis;
  logic              flag_q, flag_d, lost_q;

  assign tgt  = (target == '0) ? CNT_W'(1) : target;
  assign mis  = (misses == '0) ? MISS_W'(1) : misses;
  assign flag = flag_q;
  assign lost = lost_q;

  always_comb begin
    cnt_d  = cnt_q;
    miss_d = miss_q;
    flag_d = flag_q;
    drop   = 1'b0;
    if (eval) begin
      if (hit) begin
        cnt_d  = (cnt_q >= tgt) ? tgt : cnt_q + 1'b1;
        miss_d = '0;
      end else if (flag_q) begin
        miss_d = miss_q + 1'b1;
      end else begin
        cnt_d = '0;
      end
      // Dropping wins over any simultaneous set.
      if (flag_q && !hit && miss_d >= mis) begin
        flag_d = 1'b0;
        cnt_d  = '0;
        miss_d = '0;
        drop   = 1'b1;
      end else if (cnt_d >= tgt) begin
        flag_d = 1'b1;
      end
    end
    if (kill) begin
      cnt_d  = '0;
      miss_d = '0;
      flag_d = 1'b0;
      drop   = flag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst || clr) begin
      cnt_q  <= '0;
      miss_q <= '0;
      flag_q <= 1'b0;
      lost_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      miss_q <= miss_d;
      flag_q <= flag_d;
      lost_q <= drop;
    end
  end
endmodule

// File: rtl/therm_to_bin.sv
// TDC thermometer decoder: binary output is the number of set bits in the code.
module therm_to_bin #(
  parameter int TDC_SIZE = 255,
  parameter int OUT_W    = 8
) (
  input  logic [TDC_SIZE-1:0] therm,
  output logic [OUT_W-1:0]    bin
);
  always_comb begin
    bin = '0;
    for (int i = 0; i < TDC_SIZE; i++) bin = bin + OUT_W'(therm[i]);
  end
endmodule

// File: rtl/epu_v2.sv
// ADPLL error processing unit: window FSM on frequency measurements, merged signed error
// word (bang-bang or proportional when unlocked, TDC phase when locked), and lock flags.
module epu_v2
  import epu_pkg::*;
#(
  parameter int ERR_SIZE   = 8,
  parameter int N_SIZE     = 8,
  parameter int TDC_SIZE   = 255,
  parameter int RANGE_W    = 2,
  parameter int LOCK_CNT_W = 10,
  parameter int MISS_W     = 3,
  parameter int GAIN_SHIFT = 2
) (
  input  logic     clk_ref,
  input  logic     n_rst,
  input  logic     VDD,
  input  logic     VSS,
  epu_v2_if.slave  bus
);
  localparam int W = N_SIZE + 2;
  localparam logic signed [ERR_SIZE-1:0] E_MAX = {1'b0, {(ERR_SIZE-1){1'b1}}};
  localparam logic signed [ERR_SIZE-1:0] E_MIN = {1'b1, {(ERR_SIZE-1){1'b0}}};

  f_mode_t                    mode_q, mode_d;
  logic signed [ERR_SIZE-1:0] epu_q, epu_d, tdc_err;
  logic [ERR_SIZE-1:0]        t2b;
  logic signed [W-1:0]        lo, hi, fq;
  logic signed [31:0]         prop_err;
  logic [ERR_SIZE:0]          err_ext, err_abs;
  logic                       hit, p_hit, f_drop;
  logic                       unused_sup, unused_p_lost, unused_p_drop;

  therm_to_bin #(.TDC_SIZE(TDC_SIZE), .OUT_W(ERR_SIZE)) u_t2b (
    .therm(bus.tdc_therm), .bin(t2b)
  );

  assign tdc_err              = signed'(t2b);
  assign unused_sup           = VDD ^ VSS;
  assign bus.therm_to_bin_out = t2b;
  assign bus.epu_out          = epu_q;
  assign bus.f_mode           = mode_q;

  always_comb begin
    // Window bounds carry two extra bits so n-range and n+range never wrap.
    fq = signed'({2'b00, bus.freq});
    lo = signed'({2'b00, bus.n}) - signed'(W'(bus.freq_lock_range));
    hi = signed'({2'b00, bus.n}) + signed'(W'(bus.freq_lock_range));
    mode_d = mode_q;
    if (bus.freq_valid) begin
      if (fq < lo)      mode_d = F_SLOW;
      else if (fq > hi) mode_d = F_FAST;
      else              mode_d = F_LOCKED;
    end

    prop_err = (signed'(32'(bus.n)) - signed'(32'(bus.freq))) <<< GAIN_SHIFT;
    case (mode_q)
      F_LOCKED: epu_d = tdc_err;
      F_SLOW:   epu_d = bus.mode_prop ? ERR_SIZE'(sat_signed(prop_err, ERR_SIZE)) : E_MAX;
      F_FAST:   epu_d = bus.mode_prop ? ERR_SIZE'(sat_signed(prop_err, ERR_SIZE)) : E_MIN;
      default:  epu_d = '0;
    endcase

    err_ext = {tdc_err[ERR_SIZE-1], tdc_err};
    err_abs = err_ext[ERR_SIZE] ? (~err_ext + 1'b1) : err_ext;
    hit     = bus.freq_valid && (mode_q == F_LOCKED) && (mode_d == F_LOCKED);
    p_hit   = hit && (err_abs <= {2'b00, bus.phase_window});
  end

  always_ff @(posedge clk_ref) begin
    if (!n_rst || !bus.enable) begin
      mode_q <= RESET;
      epu_q  <= '0;
    end else begin
      mode_q <= mode_d;
      epu_q  <= epu_d;
    end
  end

  epu_lock_tracker #(.CNT_W(LOCK_CNT_W), .MISS_W(MISS_W)) u_freq_lock (
    .clk(clk_ref), .n_rst(n_rst), .clr(!bus.enable), .kill(1'b0),
    .eval(bus.freq_valid), .hit(hit),
    .target(bus.lock_target), .misses(bus.unlock_misses),
    .flag(bus.freq_locked), .lost(bus.lock_lost), .drop(f_drop)
  );

  // Phase lock is only meaningful under frequency lock, so a frequency drop kills it.
  epu_lock_tracker #(.CNT_W(LOCK_CNT_W), .MISS_W(MISS_W)) u_phase_lock (
    .clk(clk_ref), .n_rst(n_rst), .clr(!bus.enable), .kill(f_drop),
    .eval(bus.freq_valid), .hit(p_hit),
    .target(bus.lock_target), .misses(bus.unlock_misses),
    .flag(bus.phase_locked), .lost(unused_p_lost), .drop(unused_p_drop)
  );
endmodule

// File: tb/tb_epu_v2.sv
// Scoreboard bench for epu_v2: directed scenarios plus randomized measurement streams
// checked against a per-measurement behavioural model of the lock rules.
module tb_epu_v2;
  logic clk_ref = 1'b0;
  logic n_rst   = 1'b0;
  logic VDD     = 1'b1;
  logic VSS     = 1'b0;
  always #5 clk_ref = ~clk_ref;

  epu_v2_if bus();

  epu_v2 dut (
    .clk_ref(clk_ref), .n_rst(n_rst), .VDD(VDD), .VSS(VSS), .bus(bus)
  );

  typedef struct {
    int mode;
    int epu;
    bit fl;
    bit pl;
    int lost;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_fail = 0, lost_seen = 0;
  bit   chk_req = 1'b0;
  logic [254:0] ones = '1;

  // reference model state
  int m_mode, fcnt, fmiss, pcnt, pmiss, lost_exp;
  bit fl, pl;
  int n_v, rg, lt, um, pw, cur_freq, cur_k;
  bit prop;

  function automatic int tdc_val(input int k);
    return (k >= 128) ? k - 256 : k;
  endfunction

  function automatic int exp_epu();
    int d;
    case (m_mode)
      0: return 0;
      1: return tdc_val(cur_k);
      default: begin
        if (!prop) return (m_mode == 2) ? 127 : -128;
        d = (n_v - cur_freq) * 4;
        return (d > 127) ? 127 : (d < -128) ? -128 : d;
      end
    endcase
  endfunction

  task automatic track(input bit h, inout int cnt, inout int miss, inout bit flag, output bit drop);
    int tg = (lt == 0) ? 1 : lt;
    int mm = (um == 0) ? 1 : um;
    drop = 1'b0;
    if (flag) begin
      if (h) miss = 0;
      else begin
        miss++;
        if (miss >= mm) begin flag = 0; cnt = 0; miss = 0; drop = 1'b1; end
      end
    end else begin
      cnt = h ? ((cnt + 1 > tg) ? tg : cnt + 1) : 0;
      if (cnt >= tg) flag = 1;
    end
  endtask

  task automatic model_step(input int f, input int k);
    int nm, e;
    bit hit, phit, fdrop, pdrop;
    nm   = (f < n_v - rg) ? 2 : (f > n_v + rg) ? 3 : 1;
    hit  = (m_mode == 1) && (nm == 1);
    e    = tdc_val(k);
    phit = hit && (((e < 0) ? -e : e) <= pw);
    track(hit, fcnt, fmiss, fl, fdrop);
    track(phit, pcnt, pmiss, pl, pdrop);
    if (fdrop) begin lost_exp++; pcnt = 0; pmiss = 0; pl = 0; end
    m_mode = nm; cur_freq = f; cur_k = k;
  endtask

  task automatic model_clear();
    m_mode = 0; fcnt = 0; fmiss = 0; pcnt = 0; pmiss = 0; fl = 0; pl = 0;
  endtask

  task automatic push_exp();
    exp_t e;
    e.mode = m_mode; e.epu = exp_epu(); e.fl = fl; e.pl = pl; e.lost = lost_exp;
    q.push_back(e);
    chk_req = 1'b1;
    @(negedge clk_ref);
    chk_req = 1'b0;
  endtask

  task automatic set_cfg(input int nn, input int r, input int t, input int m, input int w, input bit p);
    n_v = nn; rg = r; lt = t; um = m; pw = w; prop = p;
    bus.n = 8'(nn); bus.freq_lock_range = 2'(r); bus.lock_target = 10'(t);
    bus.unlock_misses = 3'(m); bus.phase_window = 7'(w); bus.mode_prop = p;
  endtask

  task automatic meas(input int f, input int k);
    @(negedge clk_ref);
    bus.freq = 8'(f); bus.tdc_therm = ones >> (255 - k); bus.freq_valid = 1'b1;
    model_step(f, k);
    @(negedge clk_ref);
    bus.freq_valid = 1'b0;
    @(negedge clk_ref);
    push_exp();
  endtask

  task automatic do_clear(input bit use_rst, input int cycles);
    @(negedge clk_ref);
    if (use_rst) n_rst = 1'b0; else bus.enable = 1'b0;
    model_clear();
    if (cycles >= 2) begin
      @(negedge clk_ref);
      push_exp();
      repeat (cycles - 2) @(negedge clk_ref);
    end else begin
      repeat (cycles) @(negedge clk_ref);
    end
    n_rst = 1'b1; bus.enable = 1'b1;
    @(negedge clk_ref);
    push_exp();
  endtask

  function automatic void check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // monitor: counts lock_lost pulses every cycle, compares when a check is presented
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_ref);
      #2;
      if (bus.lock_lost === 1'b1) lost_seen++;
      if (chk_req) begin
        if (q.size() == 0) check("scoreboard_empty", 0, 1);
        else begin
          e = q.pop_front();
          check("f_mode", int'(bus.f_mode), e.mode);
          check("epu_out", int'($signed(bus.epu_out)), e.epu);
          check("freq_locked", int'(bus.freq_locked), int'(e.fl));
          check("phase_locked", int'(bus.phase_locked), int'(e.pl));
          check("lock_lost_pulses", lost_seen, e.lost);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_chk);
    $fatal(1);
  end

  initial begin
    int nn, f, k;
    lost_exp = 0; cur_freq = 0; cur_k = 0;
    bus.enable = 1'b1; bus.freq_valid = 1'b0; bus.freq = '0; bus.tdc_therm = '0;
    set_cfg(100, 2, 4, 2, 10, 1'b0);
    model_clear();
    do_clear(1'b1, 2);

    // bang-bang then proportional
    meas(90, 0);
    meas(110, 0);
    set_cfg(100, 2, 4, 2, 10, 1'b1);
    meas(95, 0);
    meas(60, 0);
    meas(140, 0);
    set_cfg(100, 2, 4, 2, 10, 1'b0);

    // frequency + phase lock with tdc_error=-10, then hysteresis and drop
    repeat (5) meas(101, 246);
    meas(90, 246);
    meas(90, 246);

    // relock with tdc_error=-128: freq locks, phase never does; then reset mid-lock
    repeat (5) meas(101, 128);
    do_clear(1'b1, 2);

    // window boundaries without wrap, then single-cycle enable clear
    set_cfg(0, 2, 4, 2, 10, 1'b0);
    meas(1, 5);
    set_cfg(255, 2, 4, 2, 10, 1'b0);
    meas(255, 5);
    do_clear(1'b0, 1);

    // randomized configurations and measurement streams
    for (int b = 0; b < 6; b++) begin
      nn = int'($urandom_range(20, 235));
      set_cfg(nn, int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 127)), 1'($urandom_range(0, 1)));
      do_clear(1'b0, 1);
      for (int i = 0; i < 30; i++) begin
        if ($urandom_range(0, 9) == 0) f = int'($urandom_range(0, 255));
        else f = nn + int'($urandom_range(0, 8)) - 4;
        case ($urandom_range(0, 3))
          0: k = int'($urandom_range(0, 12));
          1: k = int'($urandom_range(243, 255));
          2: k = 128;
          default: k = int'($urandom_range(0, 255));
        endcase
        meas(f, k);
      end
    end

    repeat (3) @(negedge clk_ref);
    check("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
